toggle_bram_responder: RTL and testbench

//  Memory responder for the toggle-handshake stack interface driven by generated FSMs (u_en/en, wr_en, addr, d_in, d_out).

---
 rtl/toggle_bram_responder_if.sv | 32 +++
 rtl/toggle_bram_responder.sv | 138 +++++++++++++
 tb/tb_toggle_bram_responder.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/toggle_bram_responder_if.sv
// Bundle of the toggle-handshake datapath port and the valid/ready host port.
// The master modport drives requests; the slave modport drives responses.
interface toggle_bram_responder_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic              u_en;
    logic              wr_en;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] d_in;
    logic              en;
    logic [DATA_W-1:0] d_out;
    logic              h_valid;
    logic              h_ready;
    logic              h_we;
    logic [ADDR_W-1:0] h_addr;
    logic [DATA_W-1:0] h_wdata;
    logic              h_rvalid;
    logic              h_rready;
    logic [DATA_W-1:0] h_rdata;
    logic              err;

    modport master (
        output u_en, wr_en, addr, d_in, h_valid, h_we, h_addr, h_wdata, h_rready,
        input  en, d_out, h_ready, h_rvalid, h_rdata, err
    );

    modport slave (
        input  u_en, wr_en, addr, d_in, h_valid, h_we, h_addr, h_wdata, h_rready,
        output en, d_out, h_ready, h_rvalid, h_rdata, err
    );
endinterface

// File: rtl/toggle_bram_responder.sv
// Single-port word memory serving a toggle-handshake datapath and a host load/dump port.
// state | meaning
// IDLE  | no access; datapath mismatch wins, otherwise host request accepted
// DP    | serve datapath request, en follows u_en
// HW    | host write of captured address/data
// HR    | host read into h_rdata
// HRSP  | hold h_rvalid until h_rready
module toggle_bram_responder #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 32
) (
    input logic                     clk,
    input logic                     reset,
    toggle_bram_responder_if.slave  bus
);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DP,
        S_HW,
        S_HR,
        S_HRSP
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_en;
    logic [DATA_W-1:0] r_d_out;
    logic              r_h_rvalid;
    logic [DATA_W-1:0] r_h_rdata;
    logic              r_err;
    logic [ADDR_W-1:0] r_h_addr;
    logic [DATA_W-1:0] r_h_wdata;

    logic              w_accept;
    logic              w_access;
    logic              w_mem_we;
    logic [ADDR_W-1:0] w_acc_addr;
    logic [DATA_W-1:0] w_mem_wdata;
    logic              w_in_range;
    logic [IDX_W-1:0]  w_idx;
    logic [DATA_W-1:0] w_rd_word;

    (* ram_style = "block" *) logic [DATA_W-1:0] r_mem [DEPTH];

    // Host is held off whenever a datapath request is outstanding.
    assign bus.h_ready = (r_state == S_IDLE) && (bus.u_en == r_en);

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_access    = 1'b0;
        w_mem_we    = 1'b0;
        w_acc_addr  = r_h_addr;
        w_mem_wdata = r_h_wdata;
        case (r_state)
            S_IDLE: begin
                if (bus.u_en != r_en) begin
                    w_state_nxt = S_DP;
                end else if (bus.h_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = bus.h_we ? S_HW : S_HR;
                end
            end
            S_DP: begin
                w_access    = 1'b1;
                w_acc_addr  = bus.addr;
                w_mem_wdata = bus.d_in;
                w_mem_we    = bus.wr_en;
                w_state_nxt = S_IDLE;
            end
            S_HW: begin
                w_access    = 1'b1;
                w_mem_we    = 1'b1;
                w_state_nxt = S_IDLE;
            end
            S_HR: begin
                w_access    = 1'b1;
                w_state_nxt = S_HRSP;
            end
            S_HRSP: begin
                if (bus.h_rready) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Full-width compare so large addresses never alias onto low words.
    assign w_in_range = (w_acc_addr < ADDR_W'(DEPTH));
    assign w_idx      = w_acc_addr[IDX_W-1:0];
    assign w_rd_word  = w_in_range ? r_mem[w_idx] : '0;

    always_ff @(posedge clk) begin
        if (w_mem_we && w_in_range) r_mem[w_idx] <= w_mem_wdata;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_en       <= 1'b0;
            r_d_out    <= '0;
            r_h_rvalid <= 1'b0;
            r_h_rdata  <= '0;
            r_err      <= 1'b0;
            r_h_addr   <= '0;
            r_h_wdata  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_h_addr  <= bus.h_addr;
                r_h_wdata <= bus.h_wdata;
            end
            if (w_access && !w_in_range) r_err <= 1'b1;
            case (r_state)
                S_DP: begin
                    r_en <= bus.u_en;
                    if (!bus.wr_en) r_d_out <= w_rd_word;
                end
                S_HR: begin
                    r_h_rdata  <= w_rd_word;
                    r_h_rvalid <= 1'b1;
                end
                S_HRSP: begin
                    if (bus.h_rready) r_h_rvalid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign bus.en       = r_en;
    assign bus.d_out    = r_d_out;
    assign bus.h_rvalid = r_h_rvalid;
    assign bus.h_rdata  = r_h_rdata;
    assign bus.err      = r_err;
endmodule

// File: tb/tb_toggle_bram_responder.sv
// Directed bench for toggle_bram_responder: datapath toggles, host port, collisions, range errors.
module tb_toggle_bram_responder;
    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    toggle_bram_responder_if #(.DATA_W(32), .ADDR_W(32)) bus ();

    toggle_bram_responder #(.DATA_W(32), .DEPTH(16), .ADDR_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic dp_req(input logic we, input logic [31:0] a, input logic [31:0] d);
        bus.wr_en = we;
        bus.addr  = a;
        bus.d_in  = d;
        bus.u_en  = ~bus.u_en;
    endtask

    task automatic wait_en(output int cyc);
        cyc = -1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (bus.en === bus.u_en) begin
                cyc = i;
                break;
            end
        end
    endtask

    task automatic host_write(input logic [31:0] a, input logic [31:0] d, output int acc);
        logic rdy;
        bus.h_valid = 1'b1;
        bus.h_we    = 1'b1;
        bus.h_addr  = a;
        bus.h_wdata = d;
        acc = -1;
        for (int i = 1; i <= 20; i++) begin
            rdy = bus.h_ready;
            @(posedge clk); #1;
            if (rdy) begin
                acc = i;
                break;
            end
        end
        bus.h_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic host_read(input logic [31:0] a, output int rv);
        logic rdy;
        bus.h_valid = 1'b1;
        bus.h_we    = 1'b0;
        bus.h_addr  = a;
        rv = -1;
        for (int i = 1; i <= 20; i++) begin
            rdy = bus.h_ready;
            @(posedge clk); #1;
            if (rdy) break;
        end
        bus.h_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bus.h_rvalid === 1'b1) begin
                rv = i;
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        int cyc;
        int rv;
        reset = 1'b1;
        bus.u_en = 1'b1; bus.wr_en = 1'b1; bus.addr = 32'd0; bus.d_in = 32'hAA;
        bus.h_valid = 1'b0; bus.h_we = 1'b0; bus.h_addr = '0; bus.h_wdata = '0; bus.h_rready = 1'b1;
        #2 reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (bus.en !== 1'b0) begin n_fail++; $display("FAIL reset_en got %b want 0", bus.en); end
        n_checks++; if (bus.d_out !== 32'd0) begin n_fail++; $display("FAIL reset_dout got %h want 0", bus.d_out); end
        n_checks++; if (bus.err !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b want 0", bus.err); end
        n_checks++; if (bus.h_rvalid !== 1'b0) begin n_fail++; $display("FAIL reset_rvalid got %b want 0", bus.h_rvalid); end
        n_checks++; if (bus.h_ready !== 1'b0) begin n_fail++; $display("FAIL reset_hready got %b want 0", bus.h_ready); end
        bus.d_in = 32'h55;
        reset = 1'b1;
        wait_en(cyc);
        n_checks++; if (cyc != 2) begin n_fail++; $display("FAIL reset_release_latency got %0d want 2", cyc); end
        host_read(32'd0, rv);
        n_checks++; if (rv < 0 || bus.h_rdata !== 32'h55) begin n_fail++; $display("FAIL reset_single_write got %h (rv %0d) want 00000055", bus.h_rdata, rv); end
        @(posedge clk); #1;
    endtask

    task automatic test_dp_write_read();
        int cyc;
        dp_req(1'b1, 32'd0, 32'd3);
        wait_en(cyc);
        n_checks++; if (cyc != 2) begin n_fail++; $display("FAIL dp_wr0_latency got %0d want 2", cyc); end
        dp_req(1'b1, 32'd1, 32'd6);
        wait_en(cyc);
        n_checks++; if (cyc != 2) begin n_fail++; $display("FAIL dp_wr1_latency got %0d want 2", cyc); end
        dp_req(1'b0, 32'd0, 32'd0);
        wait_en(cyc);
        n_checks++; if (cyc != 2 || bus.d_out !== 32'd3) begin n_fail++; $display("FAIL dp_rd0 got %h lat %0d want 00000003 lat 2", bus.d_out, cyc); end
        dp_req(1'b0, 32'd1, 32'd0);
        wait_en(cyc);
        n_checks++; if (cyc != 2 || bus.d_out !== 32'd6) begin n_fail++; $display("FAIL dp_rd1 got %h lat %0d want 00000006 lat 2", bus.d_out, cyc); end
    endtask

    task automatic test_host_preload();
        int acc;
        int cyc;
        host_write(32'd5, 32'hDEADBEEF, acc);
        n_checks++; if (acc != 1) begin n_fail++; $display("FAIL host_wr_accept got %0d want 1", acc); end
        n_checks++; if (bus.d_out !== 32'd6) begin n_fail++; $display("FAIL dout_hold got %h want 00000006", bus.d_out); end
        dp_req(1'b0, 32'd5, 32'd0);
        wait_en(cyc);
        n_checks++; if (cyc != 2 || bus.d_out !== 32'hDEADBEEF) begin n_fail++; $display("FAIL preload_read got %h lat %0d want deadbeef lat 2", bus.d_out, cyc); end
    endtask

    task automatic test_collision();
        bus.h_rready = 1'b1;
        dp_req(1'b1, 32'd2, 32'h77);
        bus.h_valid = 1'b1; bus.h_we = 1'b0; bus.h_addr = 32'd2;
        #1;
        n_checks++; if (bus.h_ready !== 1'b0) begin n_fail++; $display("FAIL coll_hready0 got %b want 0", bus.h_ready); end
        @(posedge clk); #1;
        n_checks++; if (bus.h_ready !== 1'b0 || bus.en === bus.u_en) begin n_fail++; $display("FAIL coll_dp_pending hready %b en %b want 0 and en!=u_en", bus.h_ready, bus.en); end
        @(posedge clk); #1;
        n_checks++; if (bus.en !== bus.u_en || bus.h_ready !== 1'b1) begin n_fail++; $display("FAIL coll_dp_done en %b hready %b want en=u_en hready 1", bus.en, bus.h_ready); end
        @(posedge clk); #1;
        bus.h_valid = 1'b0;
        @(posedge clk); #1;
        n_checks++; if (bus.h_rvalid !== 1'b1 || bus.h_rdata !== 32'h77) begin n_fail++; $display("FAIL coll_host_read rvalid %b data %h want 1 00000077", bus.h_rvalid, bus.h_rdata); end
        @(posedge clk); #1;
        n_checks++; if (bus.h_rvalid !== 1'b0) begin n_fail++; $display("FAIL coll_rvalid_clear got %b want 0", bus.h_rvalid); end
    endtask

    task automatic test_backpressure();
        int rv;
        int cyc;
        bus.h_rready = 1'b0;
        host_read(32'd1, rv);
        n_checks++; if (rv < 0 || bus.h_rdata !== 32'd6) begin n_fail++; $display("FAIL bp_read got %h rv %0d want 00000006", bus.h_rdata, rv); end
        dp_req(1'b0, 32'd0, 32'd0);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            n_checks++;
            if (bus.h_rvalid !== 1'b1 || bus.h_rdata !== 32'd6 || bus.en === bus.u_en) begin
                n_fail++;
                $display("FAIL bp_hold cycle %0d rvalid %b data %h en %b want 1 00000006 en!=u_en", i, bus.h_rvalid, bus.h_rdata, bus.en);
            end
        end
        bus.h_rready = 1'b1;
        @(posedge clk); #1;
        n_checks++; if (bus.h_rvalid !== 1'b0) begin n_fail++; $display("FAIL bp_release got %b want 0", bus.h_rvalid); end
        wait_en(cyc);
        n_checks++; if (cyc != 2 || bus.d_out !== 32'd3) begin n_fail++; $display("FAIL bp_dp_after got %h lat %0d want 00000003 lat 2", bus.d_out, cyc); end
    endtask

    task automatic test_out_of_range();
        int cyc;
        int rv;
        n_checks++; if (bus.err !== 1'b0) begin n_fail++; $display("FAIL oor_err_pre got %b want 0", bus.err); end
        dp_req(1'b1, 32'd16, 32'h1234);
        wait_en(cyc);
        n_checks++; if (cyc != 2 || bus.err !== 1'b1) begin n_fail++; $display("FAIL oor_write err %b lat %0d want 1 lat 2", bus.err, cyc); end
        dp_req(1'b0, 32'd16, 32'd0);
        wait_en(cyc);
        n_checks++; if (cyc != 2 || bus.d_out !== 32'd0) begin n_fail++; $display("FAIL oor_read got %h lat %0d want 0 lat 2", bus.d_out, cyc); end
        dp_req(1'b0, 32'd0, 32'd0);
        wait_en(cyc);
        n_checks++; if (bus.d_out !== 32'd3 || bus.err !== 1'b1) begin n_fail++; $display("FAIL oor_no_wrap got %h err %b want 00000003 err 1", bus.d_out, bus.err); end
        dp_req(1'b0, 32'h8000_0000, 32'd0);
        wait_en(cyc);
        n_checks++; if (cyc != 2 || bus.d_out !== 32'd0) begin n_fail++; $display("FAIL oor_high_addr got %h lat %0d want 0 lat 2", bus.d_out, cyc); end
        bus.h_rready = 1'b0;
        host_read(32'd16, rv);
        n_checks++; if (rv < 0 || bus.h_rdata !== 32'd0) begin n_fail++; $display("FAIL oor_host_read got %h rv %0d want 0", bus.h_rdata, rv); end
        bus.h_rready = 1'b1;
        @(posedge clk); #1;
        bus.u_en = 1'b0;
        reset = 1'b0;
        #1;
        n_checks++; if (bus.err !== 1'b0 || bus.en !== 1'b0 || bus.d_out !== 32'd0) begin n_fail++; $display("FAIL oor_reset err %b en %b dout %h want 0 0 0", bus.err, bus.en, bus.d_out); end
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        n_checks++; if (bus.err !== 1'b0 || bus.h_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset err %b hready %b want 0 1", bus.err, bus.h_ready); end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_dp_write_read();
        test_host_preload();
        test_collision();
        test_backpressure();
        test_out_of_range();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
